// File: rtl/regbank_arbiter.sv
// Round-robin arbiter that serialises single-bit read/write accesses from
// NREQ requesters onto a bank of DEPTH enable-controlled flops.
module regbank_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_we,
  input  logic [NREQ*AW-1:0]   i_addr,
  input  logic [NREQ-1:0]      i_wdata,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_ack,
  output logic                 o_rdata,
  output logic                 o_busy,
  output logic [DEPTH-1:0]     o_bank_q
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           r_state, w_nextState;
  logic [PW-1:0]    r_ptr, w_nextPtr;
  logic [PW-1:0]    r_win, w_nextWin, w_pick;
  logic [NREQ-1:0]  r_gnt, w_nextGnt;
  logic [NREQ-1:0]  r_ack, w_nextAck;
  logic [NREQ-1:0]  w_eligible;
  logic             r_rdata, w_nextRdata;
  logic             w_found, w_inRange, w_rdBit;
  logic [AW-1:0]    w_addr;
  logic [DEPTH-1:0] r_bank, w_bankWe;

  // A requester is hidden during its own ack cycle so it cannot be re-granted back-to-back.
  assign w_eligible = i_req & ~r_ack;

  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && w_eligible[idx]) begin
        w_found = 1'b1;
        w_pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    w_addr    = i_addr[int'(r_win)*AW +: AW];
    w_inRange = (int'(w_addr) < DEPTH);
    w_rdBit   = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (int'(w_addr) == j) begin
        w_rdBit = r_bank[j];
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextWin   = r_win;
    w_nextGnt   = '0;
    w_nextAck   = '0;
    w_nextRdata = r_rdata;
    w_bankWe    = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextGnt   = NREQ'(1) << w_pick;
          w_nextWin   = w_pick;
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        // The pointer advances even when the requester abandoned its access.
        w_nextPtr   = (r_win == PW'(NREQ-1)) ? '0 : r_win + 1'b1;
        w_nextState = IDLE;
        if (i_req[r_win]) begin
          w_nextAck   = NREQ'(1) << r_win;
          w_nextRdata = w_inRange ? w_rdBit : 1'b0;
          for (int j = 0; j < DEPTH; j++) begin
            w_bankWe[j] = i_we[r_win] && w_inRange && (int'(w_addr) == j);
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_rdata <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_win   <= w_nextWin;
      r_gnt   <= w_nextGnt;
      r_ack   <= w_nextAck;
      r_rdata <= w_nextRdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (w_bankWe[j]) begin
          r_bank[j] <= i_wdata[r_win];
        end
      end
    end
  end

  assign o_gnt    = r_gnt;
  assign o_ack    = r_ack;
  assign o_rdata  = r_rdata;
  assign o_busy   = (r_state == ACCESS);
  assign o_bank_q = r_bank;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_regbank_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int NVEC  = 12;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req, we, wdata;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ-1:0]      gnt, ack;
  logic                 rdata, busy;
  logic [DEPTH-1:0]     bankQ;

  int nCompared;
  int nMismatched;

  int               mGrant;
  int               mPtr;
  logic [NREQ-1:0]  mAck;
  logic             mRdata;
  logic [DEPTH-1:0] mBank;

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    wdata;
    logic [NREQ-1:0]    expGnt;
    logic [NREQ-1:0]    expAck;
    logic               expRdata;
    logic [DEPTH-1:0]   expBank;
  } vec_t;

  vec_t vecs[NVEC];

  regbank_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_we     (we),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_gnt    (gnt),
    .o_ack    (ack),
    .o_rdata  (rdata),
    .o_busy   (busy),
    .o_bank_q (bankQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pickNext(input int start, input logic [NREQ-1:0] elig);
    for (int k = 0; k < NREQ; k++) begin
      if (elig[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mGrant = -1;
    mPtr   = 0;
    mAck   = '0;
    mRdata = 1'b0;
    mBank  = '0;
  endtask

  // One edge of the reference: either finish the outstanding access or pick a new winner.
  task automatic modelStep();
    int a;
    if (mGrant >= 0) begin
      if (req[mGrant]) begin
        a = int'(addr[mGrant*AW +: AW]);
        if (a < DEPTH) begin
          mRdata = mBank[a];
          if (we[mGrant]) mBank[a] = wdata[mGrant];
        end else begin
          mRdata = 1'b0;
        end
        mAck = '0;
        mAck[mGrant] = 1'b1;
      end else begin
        mAck = '0;
      end
      mPtr   = (mGrant + 1) % NREQ;
      mGrant = -1;
    end else begin
      mGrant = pickNext(mPtr, req & ~mAck);
      mAck   = '0;
    end
  endtask

  task automatic cycleOnce();
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep();
    @(negedge clk);
  endtask

  task automatic checkModel(input string tag);
    logic [NREQ-1:0] expGnt;
    expGnt = '0;
    if (mGrant >= 0) expGnt[mGrant] = 1'b1;
    checkOutput({tag, " gnt"},   32'(gnt),   32'(expGnt));
    checkOutput({tag, " ack"},   32'(ack),   32'(mAck));
    checkOutput({tag, " rdata"}, 32'(rdata), 32'(mRdata));
    checkOutput({tag, " busy"},  32'(busy),  32'(mGrant >= 0));
    checkOutput({tag, " bank"},  32'(bankQ), 32'(mBank));
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                               input logic [NREQ*AW-1:0] a, input logic [NREQ-1:0] d);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  // Pull reset low between edges so only its asynchronous path can clear the outputs.
  task automatic asyncReset(input string tag);
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkModel({tag, " async"});
  endtask

  task automatic fullReset();
    @(negedge clk);
    asyncReset("rst");
    cycleOnce();
    rst_n = 1'b1;
  endtask

  task automatic driveRandom();
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if ($urandom_range(0, 5) == 0) req[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req[i]             = 1'b1;
        we[i]              = 1'($urandom);
        wdata[i]           = 1'($urandom);
        addr[i*AW +: AW]   = AW'($urandom_range(0, 7));
      end
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b1;
    modelReset();
    applyStimulus('0, '0, '0, '0);

    vecs[0]  = '{4'b0001, 4'b0001, 12'o0005, 4'b0001, 4'b0001, 4'b0000, 1'b0, 6'b000000};
    vecs[1]  = '{4'b0001, 4'b0001, 12'o0005, 4'b0001, 4'b0000, 4'b0001, 1'b0, 6'b100000};
    vecs[2]  = '{4'b0000, 4'b0000, 12'o0005, 4'b0000, 4'b0000, 4'b0000, 1'b0, 6'b100000};
    vecs[3]  = '{4'b0001, 4'b0000, 12'o0005, 4'b0000, 4'b0001, 4'b0000, 1'b0, 6'b100000};
    vecs[4]  = '{4'b0001, 4'b0000, 12'o0005, 4'b0000, 4'b0000, 4'b0001, 1'b1, 6'b100000};
    vecs[5]  = '{4'b0000, 4'b0000, 12'o0005, 4'b0000, 4'b0000, 4'b0000, 1'b1, 6'b100000};
    vecs[6]  = '{4'b0100, 4'b0000, 12'o0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 6'b100000};
    vecs[7]  = '{4'b0100, 4'b0000, 12'o0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 6'b100000};
    vecs[8]  = '{4'b0100, 4'b0000, 12'o0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 6'b100000};
    vecs[9]  = '{4'b0100, 4'b0000, 12'o0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 6'b100000};
    vecs[10] = '{4'b0100, 4'b0000, 12'o0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 6'b100000};
    vecs[11] = '{4'b0000, 4'b0000, 12'o0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 6'b100000};

    $display("[TB] reset with random inputs");
    applyStimulus(4'($urandom), 4'($urandom), 12'($urandom), 4'($urandom));
    asyncReset("init");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'($urandom), 4'($urandom), 12'($urandom), 4'($urandom));
      cycleOnce();
      checkModel("inreset");
    end
    applyStimulus('0, '0, '0, '0);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycleOnce();
      checkModel("postreset");
    end

    $display("[TB] vector table");
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      cycleOnce();
      checkOutput($sformatf("vec%0d gnt", v),   32'(gnt),   32'(vecs[v].expGnt));
      checkOutput($sformatf("vec%0d ack", v),   32'(ack),   32'(vecs[v].expAck));
      checkOutput($sformatf("vec%0d rdata", v), 32'(rdata), 32'(vecs[v].expRdata));
      checkOutput($sformatf("vec%0d busy", v),  32'(busy),  32'(|vecs[v].expGnt));
      checkOutput($sformatf("vec%0d bank", v),  32'(bankQ), 32'(vecs[v].expBank));
    end

    $display("[TB] round-robin saturation");
    fullReset();
    applyStimulus(4'b1111, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b1010);
    for (int k = 0; k < 16; k++) begin
      logic [NREQ-1:0] who;
      who = '0;
      who[(k / 2) % NREQ] = 1'b1;
      cycleOnce();
      checkOutput($sformatf("rr%0d gnt", k), 32'(gnt), (k % 2 == 0) ? 32'(who) : 32'd0);
      checkOutput($sformatf("rr%0d ack", k), 32'(ack), (k % 2 == 1) ? 32'(who) : 32'd0);
    end
    checkOutput("rr bank",  32'(bankQ), 32'(6'b001010));
    checkOutput("rr rdata", 32'(rdata), 32'd1);

    $display("[TB] abort then out-of-range write");
    applyStimulus(4'b0010, 4'b0010, {3'd3, 3'd2, 3'd4, 3'd0}, 4'b0010);
    cycleOnce();
    checkOutput("abort gnt", 32'(gnt), 32'(4'b0010));
    applyStimulus(4'b1001, 4'b1000, {3'd7, 3'd2, 3'd4, 3'd0}, 4'b1000);
    cycleOnce();
    checkOutput("abort ack",   32'(ack),   32'd0);
    checkOutput("abort gnt0",  32'(gnt),   32'd0);
    checkOutput("abort rdata", 32'(rdata), 32'd1);
    checkOutput("abort bank",  32'(bankQ), 32'(6'b001010));
    cycleOnce();
    checkOutput("abort nextgnt", 32'(gnt), 32'(4'b1000));
    cycleOnce();
    checkOutput("oor ack",   32'(ack),   32'(4'b1000));
    checkOutput("oor rdata", 32'(rdata), 32'd0);
    checkOutput("oor bank",  32'(bankQ), 32'(6'b001010));
    cycleOnce();
    checkOutput("wrap gnt", 32'(gnt), 32'(4'b0001));
    cycleOnce();
    checkOutput("wrap ack",   32'(ack),   32'(4'b0001));
    checkOutput("wrap rdata", 32'(rdata), 32'd0);
    applyStimulus('0, '0, '0, '0);

    $display("[TB] reset during access");
    fullReset();
    applyStimulus(4'b0100, 4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, 4'b0100);
    cycleOnce();
    checkOutput("midrst gnt", 32'(gnt), 32'(4'b0100));
    asyncReset("midrst");
    cycleOnce();
    checkOutput("midrst bank3", 32'(bankQ[3]), 32'd0);
    checkOutput("midrst ack",   32'(ack),      32'd0);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b0000, '0, '0);
    cycleOnce();
    checkOutput("midrst restart", 32'(gnt), 32'(4'b0001));

    $display("[TB] random traffic");
    fullReset();
    applyStimulus('0, '0, '0, '0);
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        asyncReset("rndrst");
        cycleOnce();
        checkModel("rndrst held");
        rst_n = 1'b1;
      end
      driveRandom();
      cycleOnce();
      checkModel($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
